// File: rtl/buffer_arbiter_64bit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : buffer_arbiter_64bit_pkg
// Purpose  : Shared constants, requester id type and address helper for the
//            two-port buffer arbiter.
// Contents : MODE_BYTE / MODE_WORD access-mode encodings, WORD_SHIFT and
//            word_addr_of() for byte->word address conversion,
//            BURST_MAX_DEFAULT, req_id_e requester identifier.
// Revision : 1.0 - initial release
// ============================================================================
package buffer_arbiter_64bit_pkg;

   localparam logic        MODE_BYTE         = 1'b0;
   localparam logic        MODE_WORD         = 1'b1;

   // A word is 8 bytes, so the word address drops the low three byte bits.
   localparam int unsigned WORD_SHIFT        = 3;

   localparam int unsigned BURST_MAX_DEFAULT = 4;

   typedef enum logic [0:0] {
      REQ0 = 1'b0,
      REQ1 = 1'b1
   } req_id_e;

   function automatic logic [31:0] word_addr_of(input logic [31:0] byte_addr);
      return byte_addr >> WORD_SHIFT;
   endfunction

endpackage
`default_nettype wire

// File: rtl/buffer_arbiter_64bit_rr_burst_arb.sv
`default_nettype none
// ============================================================================
// Module   : rr_burst_arb
// Purpose  : Two-requester round-robin arbiter with a bounded burst. The
//            current owner keeps the grant for up to BURST_MAX consecutive
//            cycles while the other requester waits; a lone requester is
//            served every cycle.
// Ports    : clk, rst      clock, asynchronous active-high reset
//            i_valid[1:0]  request present per requester
//            o_grant[1:0]  one-hot (or zero) grant, combinational
// Revision : 1.0 - initial release
// ============================================================================
module rr_burst_arb
   import buffer_arbiter_64bit_pkg::*;
#(
   parameter int BURST_MAX = int'(BURST_MAX_DEFAULT)
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] i_valid,
   output logic [1:0] o_grant
);

   localparam int              CNT_W       = $clog2(BURST_MAX + 1);
   localparam logic [CNT_W-1:0] c_burst_max = CNT_W'(BURST_MAX);
   localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

   req_id_e          r_owner;
   logic [CNT_W-1:0] r_burst_cnt;

   req_id_e          w_owner_nxt;
   logic [CNT_W-1:0] w_burst_cnt_nxt;
   logic             w_owner_valid;
   logic             w_other_valid;
   logic             w_serve_owner;
   logic             w_serve_other;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_owner     <= REQ0;
         r_burst_cnt <= '0;
      end else begin
         r_owner     <= w_owner_nxt;
         r_burst_cnt <= w_burst_cnt_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_owner_valid   = (r_owner == REQ1) ? i_valid[1] : i_valid[0];
      w_other_valid   = (r_owner == REQ1) ? i_valid[0] : i_valid[1];
      // Owner keeps the grant until its burst is spent, but only yields
      // when the other side actually wants the buffer.
      w_serve_owner   = w_owner_valid &&
                        ((r_burst_cnt < c_burst_max) || !w_other_valid);
      w_serve_other   = !w_serve_owner && w_other_valid;

      w_owner_nxt     = r_owner;
      w_burst_cnt_nxt = r_burst_cnt;
      if (w_serve_owner) begin
         w_burst_cnt_nxt = (r_burst_cnt < c_burst_max) ?
                           (r_burst_cnt + c_cnt_one) : c_burst_max;
      end else if (w_serve_other) begin
         w_owner_nxt     = (r_owner == REQ0) ? REQ1 : REQ0;
         w_burst_cnt_nxt = c_cnt_one;
      end else begin
         w_burst_cnt_nxt = '0;
      end
   end

   // Output logic
   always_comb begin
      o_grant = 2'b00;
      if (w_serve_owner) begin
         o_grant = (r_owner == REQ1) ? 2'b10 : 2'b01;
      end else if (w_serve_other) begin
         o_grant = (r_owner == REQ1) ? 2'b01 : 2'b10;
      end
   end

endmodule
`default_nettype wire

// File: rtl/buffer_arbiter_64bit.sv
`default_nettype none
// ============================================================================
// Module   : buffer_arbiter_64bit
// Purpose  : Shares one buffer_64bit between a loader/DMA requester (req0)
//            and a compute requester (req1). Grants one access per cycle,
//            drives the buffer ports from the served requester and routes
//            read data back to the issuer one cycle later.
// Ports    : clk, rst                 clock, asynchronous active-high reset
//            reqN_valid/ready         request handshake (N = 0, 1)
//            reqN_we/mode/addr/wdata  access fields (mode 0 byte, 1 word)
//            rspN_valid/rdata         read response, rdata 0 when not valid
//            buf_*                    buffer control/address/data (out)
//            buf_byte_out/word_out    buffer read data (in)
// Revision : 1.0 - initial release
// ============================================================================
module buffer_arbiter_64bit
   import buffer_arbiter_64bit_pkg::*;
#(
   parameter int BuffDepth = 256,
   parameter int ByteAddrW = $clog2(BuffDepth),
   parameter int WordAddrW = $clog2(BuffDepth / 8),
   parameter int BurstMax  = int'(BURST_MAX_DEFAULT)
)(
   input  logic                 clk,
   input  logic                 rst,

   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic                 req0_we,
   input  logic                 req0_mode,
   input  logic [ByteAddrW-1:0] req0_addr,
   input  logic [63:0]          req0_wdata,
   output logic                 rsp0_valid,
   output logic [63:0]          rsp0_rdata,

   input  logic                 req1_valid,
   output logic                 req1_ready,
   input  logic                 req1_we,
   input  logic                 req1_mode,
   input  logic [ByteAddrW-1:0] req1_addr,
   input  logic [63:0]          req1_wdata,
   output logic                 rsp1_valid,
   output logic [63:0]          rsp1_rdata,

   output logic                 buf_write_en,
   output logic                 buf_read_en,
   output logic                 buf_addr_mode,
   output logic [ByteAddrW-1:0] buf_byte_addr,
   output logic [WordAddrW-1:0] buf_word_addr,
   output logic [7:0]           buf_byte_in,
   output logic [63:0]          buf_word_in,
   input  logic [7:0]           buf_byte_out,
   input  logic [63:0]          buf_word_out
);

   logic [1:0]           w_grant;
   logic                 w_served;
   logic                 w_sel;
   logic                 w_we;
   logic                 w_mode;
   logic [ByteAddrW-1:0] w_addr;
   logic [63:0]          w_wdata;
   logic [63:0]          w_rd_data;
   logic                 w_rsp0_valid;
   logic                 w_rsp1_valid;

   logic                 r_rd_pend;
   req_id_e              r_rd_id;
   logic                 r_rd_mode;

   rr_burst_arb #(
      .BURST_MAX (BurstMax)
   ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .i_valid ({req1_valid, req0_valid}),
      .o_grant (w_grant)
   );

   // Select the served requester's fields
   always_comb begin
      w_served = |w_grant;
      w_sel    = w_grant[1];
      w_we     = w_sel ? req1_we    : req0_we;
      w_mode   = w_sel ? req1_mode  : req0_mode;
      w_addr   = w_sel ? req1_addr  : req0_addr;
      w_wdata  = w_sel ? req1_wdata : req0_wdata;
   end

   // rst only gates the outputs here; the registered state is already held
   // in reset asynchronously, so no flop input depends on rst.
   assign req0_ready = w_grant[0] & ~rst;
   assign req1_ready = w_grant[1] & ~rst;

   // Buffer drive: everything 0 when idle so the buffer sees no enable
   always_comb begin
      buf_write_en  = 1'b0;
      buf_read_en   = 1'b0;
      buf_addr_mode = MODE_BYTE;
      buf_byte_addr = '0;
      buf_word_addr = '0;
      buf_byte_in   = '0;
      buf_word_in   = '0;
      if (w_served && !rst) begin
         buf_write_en  = w_we;
         buf_read_en   = !w_we;
         buf_addr_mode = w_mode;
         buf_byte_addr = w_addr;
         buf_word_addr = WordAddrW'(word_addr_of(32'(w_addr)));
         buf_byte_in   = w_wdata[7:0];
         buf_word_in   = w_wdata;
      end
   end

   // Response pipeline: one-cycle tag matching the buffer's read latency
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_pend <= 1'b0;
         r_rd_id   <= REQ0;
         r_rd_mode <= MODE_BYTE;
      end else begin
         r_rd_pend <= w_served && !w_we;
         r_rd_id   <= w_sel ? REQ1 : REQ0;
         r_rd_mode <= w_mode;
      end
   end

   always_comb begin
      w_rd_data    = (r_rd_mode == MODE_WORD) ? buf_word_out : {56'b0, buf_byte_out};
      w_rsp0_valid = r_rd_pend && (r_rd_id == REQ0);
      w_rsp1_valid = r_rd_pend && (r_rd_id == REQ1);
   end

   assign rsp0_valid = w_rsp0_valid;
   assign rsp1_valid = w_rsp1_valid;
   assign rsp0_rdata = w_rsp0_valid ? w_rd_data : '0;
   assign rsp1_rdata = w_rsp1_valid ? w_rd_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_buffer_arbiter_64bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_buffer_arbiter_64bit
// Purpose  : Directed self-checking bench for buffer_arbiter_64bit with a
//            behavioural 256-byte buffer (one-cycle read latency).
// Revision : 1.0 - initial release
// ============================================================================
module tb_buffer_arbiter_64bit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req0_we, req0_mode;
   logic [7:0]  req0_addr;
   logic [63:0] req0_wdata;
   logic        rsp0_valid;
   logic [63:0] rsp0_rdata;
   logic        req1_valid, req1_ready, req1_we, req1_mode;
   logic [7:0]  req1_addr;
   logic [63:0] req1_wdata;
   logic        rsp1_valid;
   logic [63:0] rsp1_rdata;
   logic        buf_write_en, buf_read_en, buf_addr_mode;
   logic [7:0]  buf_byte_addr;
   logic [4:0]  buf_word_addr;
   logic [7:0]  buf_byte_in;
   logic [63:0] buf_word_in;
   logic [7:0]  buf_byte_out;
   logic [63:0] buf_word_out;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   buffer_arbiter_64bit #(.BuffDepth(256), .BurstMax(4)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
      .req0_mode(req0_mode), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
      .req1_mode(req1_mode), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
      .buf_write_en(buf_write_en), .buf_read_en(buf_read_en),
      .buf_addr_mode(buf_addr_mode), .buf_byte_addr(buf_byte_addr),
      .buf_word_addr(buf_word_addr), .buf_byte_in(buf_byte_in),
      .buf_word_in(buf_word_in), .buf_byte_out(buf_byte_out),
      .buf_word_out(buf_word_out)
   );

   // Behavioural buffer: little-endian words, memory holds mem[i] = i after reset
   logic [7:0] mem [0:255];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
         buf_byte_out <= '0;
         buf_word_out <= '0;
      end else begin
         if (buf_write_en) begin
            if (buf_addr_mode)
               for (int i = 0; i < 8; i++) mem[{buf_word_addr, 3'(i)}] <= buf_word_in[8*i +: 8];
            else
               mem[buf_byte_addr] <= buf_byte_in;
         end
         if (buf_read_en) begin
            buf_byte_out <= mem[buf_byte_addr];
            for (int i = 0; i < 8; i++) buf_word_out[8*i +: 8] <= mem[{buf_word_addr, 3'(i)}];
         end
      end
   end

   task automatic idle_inputs();
      req0_valid = 0; req0_we = 0; req0_mode = 0; req0_addr = '0; req0_wdata = '0;
      req1_valid = 0; req1_we = 0; req1_mode = 0; req1_addr = '0; req1_wdata = '0;
   endtask

   // Called at a falling edge; returns at a falling edge with rst released
   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req0_valid = 1; req0_we = 1; req0_mode = 1; req0_addr = 8'h5A; req0_wdata = 64'h1111;
      req1_valid = 1; req1_we = 0; req1_mode = 1; req1_addr = 8'h33; req1_wdata = 64'h2222;
      #1;
      tests_run++; if ({req0_ready, req1_ready} !== 2'b00) begin tests_failed++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready}); end
      tests_run++; if ({buf_write_en, buf_read_en, buf_addr_mode} !== 3'b000) begin tests_failed++; $display("FAIL reset_buf_ctl: got %b expected 000", {buf_write_en, buf_read_en, buf_addr_mode}); end
      tests_run++; if ({buf_byte_addr, buf_word_addr, buf_byte_in, buf_word_in} !== '0) begin tests_failed++; $display("FAIL reset_buf_data: got %h expected 0", {buf_byte_addr, buf_word_addr, buf_byte_in, buf_word_in}); end
      tests_run++; if ({rsp0_valid, rsp1_valid} !== 2'b00 || rsp0_rdata !== 64'h0 || rsp1_rdata !== 64'h0) begin tests_failed++; $display("FAIL reset_rsp: got %b/%h/%h expected 0", {rsp0_valid, rsp1_valid}, rsp0_rdata, rsp1_rdata); end
      @(negedge clk);
      idle_inputs();
      rst = 1'b0;
      #1;
      tests_run++; if ({buf_write_en, buf_read_en, req0_ready, req1_ready} !== 4'b0000) begin tests_failed++; $display("FAIL idle_after_reset: got %b expected 0000", {buf_write_en, buf_read_en, req0_ready, req1_ready}); end
      @(negedge clk);
   endtask

   task automatic test_byte_rw();
      req0_valid = 1; req0_we = 1; req0_mode = 0; req0_addr = 8'd7; req0_wdata = 64'hFF;
      #1;
      tests_run++; if ({req0_ready, req1_ready} !== 2'b10) begin tests_failed++; $display("FAIL bw_ready: got %b expected 10", {req0_ready, req1_ready}); end
      tests_run++; if ({buf_write_en, buf_read_en, buf_addr_mode, buf_byte_addr, buf_byte_in} !== {3'b100, 8'd7, 8'hFF}) begin tests_failed++; $display("FAIL bw_buf: got %h expected %h", {buf_write_en, buf_read_en, buf_addr_mode, buf_byte_addr, buf_byte_in}, {3'b100, 8'd7, 8'hFF}); end
      @(negedge clk);
      req0_we = 0;
      #1;
      tests_run++; if ({req0_ready, buf_read_en, buf_write_en, rsp0_valid} !== 4'b1100) begin tests_failed++; $display("FAIL br_issue: got %b expected 1100", {req0_ready, buf_read_en, buf_write_en, rsp0_valid}); end
      @(negedge clk);
      req0_valid = 0;
      #1;
      tests_run++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 64'h00000000000000FF) begin tests_failed++; $display("FAIL br_rsp0: got %b/%h expected 1/00000000000000ff", rsp0_valid, rsp0_rdata); end
      tests_run++; if (rsp1_valid !== 1'b0 || rsp1_rdata !== 64'h0) begin tests_failed++; $display("FAIL br_rsp1_quiet: got %b/%h expected 0/0", rsp1_valid, rsp1_rdata); end
      @(negedge clk);
      #1;
      tests_run++; if (rsp0_valid !== 1'b0 || rsp0_rdata !== 64'h0) begin tests_failed++; $display("FAIL br_rsp0_once: got %b/%h expected 0/0", rsp0_valid, rsp0_rdata); end
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      logic [9:0] pat;
      pat = 10'b0011110000;   // bit i = 1 means req1 granted in cycle i
      do_reset();
      req0_valid = 1; req0_we = 0; req0_mode = 0; req0_addr = 8'h20;
      req1_valid = 1; req1_we = 0; req1_mode = 1; req1_addr = 8'h40;
      for (int i = 0; i < 10; i++) begin
         #1;
         tests_run++; if ({req0_ready, req1_ready} !== {~pat[i], pat[i]}) begin tests_failed++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, {req0_ready, req1_ready}, {~pat[i], pat[i]}); end
         if (i > 0) begin
            if (pat[i-1]) begin
               tests_run++; if ({rsp0_valid, rsp1_valid} !== 2'b01 || rsp1_rdata !== 64'h4746454443424140) begin tests_failed++; $display("FAIL rr_rsp1[%0d]: got %b/%h expected 01/4746454443424140", i, {rsp0_valid, rsp1_valid}, rsp1_rdata); end
            end else begin
               tests_run++; if ({rsp0_valid, rsp1_valid} !== 2'b10 || rsp0_rdata !== 64'h20) begin tests_failed++; $display("FAIL rr_rsp0[%0d]: got %b/%h expected 10/20", i, {rsp0_valid, rsp1_valid}, rsp0_rdata); end
            end
         end
         @(negedge clk);
      end
      idle_inputs();
      #1;
      tests_run++; if ({rsp0_valid, rsp1_valid} !== 2'b10 || rsp0_rdata !== 64'h20) begin tests_failed++; $display("FAIL rr_rsp_last: got %b/%h expected 10/20", {rsp0_valid, rsp1_valid}, rsp0_rdata); end
      @(negedge clk);
   endtask

   task automatic test_word_then_byte();
      req0_valid = 1; req0_we = 1; req0_mode = 1; req0_addr = 8'd8; req0_wdata = 64'h0123456789ABCDEF;
      #1;
      tests_run++; if ({req0_ready, buf_write_en, buf_addr_mode, buf_word_addr} !== {3'b111, 5'd1} || buf_word_in !== 64'h0123456789ABCDEF) begin tests_failed++; $display("FAIL ww_buf: got %b/%h expected 111/01/0123456789abcdef", {req0_ready, buf_write_en, buf_addr_mode}, buf_word_addr, buf_word_in); end
      @(negedge clk);
      req0_valid = 0;
      req1_valid = 1; req1_we = 0; req1_mode = 0; req1_addr = 8'd8;
      #1;
      tests_run++; if ({req0_ready, req1_ready, buf_read_en, buf_addr_mode, buf_byte_addr} !== {4'b0110, 8'd8}) begin tests_failed++; $display("FAIL wb_issue: got %h expected %h", {req0_ready, req1_ready, buf_read_en, buf_addr_mode, buf_byte_addr}, {4'b0110, 8'd8}); end
      @(negedge clk);
      req1_valid = 0;
      #1;
      tests_run++; if ({rsp0_valid, rsp1_valid} !== 2'b01 || rsp1_rdata !== 64'hEF) begin tests_failed++; $display("FAIL wb_rsp1: got %b/%h expected 01/ef", {rsp0_valid, rsp1_valid}, rsp1_rdata); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      req0_valid = 1; req0_we = 1; req0_mode = 1; req0_addr = 8'h30; req0_wdata = 64'hDEADBEEFCAFEF00D;
      #1;
      tests_run++; if ({buf_write_en, buf_read_en} !== 2'b10 || buf_word_addr !== 5'd6) begin tests_failed++; $display("FAIL raw_wr: got %b/%h expected 10/06", {buf_write_en, buf_read_en}, buf_word_addr); end
      @(negedge clk);
      req0_valid = 0;
      req1_valid = 1; req1_we = 0; req1_mode = 1; req1_addr = 8'h33;
      #1;
      tests_run++; if ({req1_ready, buf_write_en, buf_read_en} !== 3'b101 || buf_word_addr !== 5'd6) begin tests_failed++; $display("FAIL raw_rd: got %b/%h expected 101/06", {req1_ready, buf_write_en, buf_read_en}, buf_word_addr); end
      @(negedge clk);
      req1_valid = 0;
      #1;
      tests_run++; if (rsp1_valid !== 1'b1 || rsp1_rdata !== 64'hDEADBEEFCAFEF00D) begin tests_failed++; $display("FAIL raw_rsp1: got %b/%h expected 1/deadbeefcafef00d", rsp1_valid, rsp1_rdata); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      req0_valid = 1; req0_we = 0; req0_mode = 0; req0_addr = 8'd5;
      #1;
      tests_run++; if (req0_ready !== 1'b1) begin tests_failed++; $display("FAIL rm_accept: got %b expected 1", req0_ready); end
      @(negedge clk);
      rst = 1'b1;
      req1_valid = 1; req1_we = 0; req1_mode = 1; req1_addr = 8'h40;
      #1;
      tests_run++; if ({rsp0_valid, rsp1_valid} !== 2'b00 || rsp0_rdata !== 64'h0) begin tests_failed++; $display("FAIL rm_rsp_drop: got %b/%h expected 00/0", {rsp0_valid, rsp1_valid}, rsp0_rdata); end
      tests_run++; if ({req0_ready, req1_ready, buf_write_en, buf_read_en, buf_addr_mode, buf_byte_addr, buf_word_addr} !== '0) begin tests_failed++; $display("FAIL rm_outputs: got %h expected 0", {req0_ready, req1_ready, buf_write_en, buf_read_en, buf_addr_mode, buf_byte_addr, buf_word_addr}); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      tests_run++; if (rsp0_valid !== 1'b0) begin tests_failed++; $display("FAIL rm_no_late_rsp: got %b expected 0", rsp0_valid); end
      tests_run++; if ({req0_ready, req1_ready} !== 2'b10) begin tests_failed++; $display("FAIL rm_owner0: got %b expected 10", {req0_ready, req1_ready}); end
      @(negedge clk);
      idle_inputs();
      #1;
      tests_run++; if ({rsp0_valid, rsp1_valid} !== 2'b10 || rsp0_rdata !== 64'h5) begin tests_failed++; $display("FAIL rm_resume: got %b/%h expected 10/5", {rsp0_valid, rsp1_valid}, rsp0_rdata); end
      @(negedge clk);
   endtask

   task automatic test_hold();
      int rd_cnt, rsp_cnt, gcyc;
      logic [63:0] rsp_data;
      logic granted;
      rd_cnt = 0; rsp_cnt = 0; gcyc = -1; rsp_data = '0; granted = 0;
      do_reset();
      // req1 alone first so it becomes owner with one grant of its burst used
      req1_valid = 1; req1_we = 1; req1_mode = 0; req1_addr = 8'h70; req1_wdata = 64'h99;
      #1;
      tests_run++; if (req1_ready !== 1'b1) begin tests_failed++; $display("FAIL hold_setup: got %b expected 1", req1_ready); end
      @(negedge clk);
      req0_valid = 1; req0_we = 0; req0_mode = 0; req0_addr = 8'h11;
      for (int c = 0; c < 8; c++) begin
         #1;
         if (buf_read_en) rd_cnt++;
         if (rsp0_valid) begin rsp_cnt++; rsp_data = rsp0_rdata; end
         if (req0_ready) begin gcyc = c; granted = 1; end
         @(negedge clk);
         if (granted) req0_valid = 0;
      end
      idle_inputs();
      tests_run++; if (gcyc !== 3) begin tests_failed++; $display("FAIL hold_grant_cycle: got %0d expected 3", gcyc); end
      tests_run++; if (rd_cnt !== 1) begin tests_failed++; $display("FAIL hold_read_pulses: got %0d expected 1", rd_cnt); end
      tests_run++; if (rsp_cnt !== 1 || rsp_data !== 64'h11) begin tests_failed++; $display("FAIL hold_rsp: got %0d/%h expected 1/11", rsp_cnt, rsp_data); end
      @(negedge clk);
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      test_reset();
      test_byte_rw();
      test_round_robin();
      test_word_then_byte();
      test_back_to_back();
      test_reset_mid();
      test_hold();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
